// File: rtl/ai_enc_pkg.sv
// Shared types and game-state constants for the AI state encoder.
package ai_enc_pkg;

    typedef enum logic [1:0] {
        K_PAD     = 2'b00,
        K_UNKNOWN = 2'b01,
        K_LIVE    = 2'b10,
        K_BLANK   = 2'b11
    } know_t;

    localparam logic [3:0] ST_LOAD       = 4'd1;
    localparam logic [3:0] ST_ITEM_BASE  = 4'd2;
    localparam logic [3:0] ST_SHOOT_BASE = 4'd5;

    typedef logic [3:0] item_code_t;

endpackage

// File: rtl/item_histogram.sv
// Combinational per-type count of one player's inventory slots; code 0 and codes above ITEM_TYPES are ignored.
module item_histogram
    import ai_enc_pkg::*;
#(
    parameter int ITEM_SLOTS = 6,
    parameter int ITEM_TYPES = 7,
    parameter int CW         = $clog2(ITEM_SLOTS + 1)
) (
    input  logic [ITEM_SLOTS*4-1:0]  items,
    output logic [ITEM_TYPES*CW-1:0] counts
);

    always_comb begin
        counts = '0;
        for (int s = 0; s < ITEM_SLOTS; s++) begin
            for (int t = 0; t < ITEM_TYPES; t++) begin
                if (item_code_t'(items[s*4 +: 4]) == item_code_t'(t + 1)) begin
                    counts[t*CW +: CW] = counts[t*CW +: CW] + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ai_state_encoder.sv
// Per-player shell knowledge tracker, item counter and AI turn snapshot offer.
// Optional AI_ENC_SHELL_STATS_EN adds snapshot live/blank/unknown counts.
module ai_state_encoder
    import ai_enc_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int MAX_SHELLS  = 8,
    parameter int ITEM_SLOTS  = 6,
    parameter int ITEM_TYPES  = 7,
    parameter int AI_PLAYER   = 0,
    parameter int SW          = $clog2(MAX_SHELLS + 1),
    parameter int PW          = $clog2(NUM_PLAYERS),
    parameter int CW          = $clog2(ITEM_SLOTS + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [3:0]                           i_state,
    input  logic [SW-1:0]                        i_total_shells,
    input  logic [SW-1:0]                        i_shell_ptr,
    input  logic [MAX_SHELLS-1:0]                i_shell_map,
    input  logic                                 i_report_valid,
    input  logic [PW-1:0]                        i_report_player,
    input  logic [SW-1:0]                        i_report_idx,
    input  logic                                 i_report_live,
    input  logic [NUM_PLAYERS*ITEM_SLOTS*4-1:0]  i_items,
    output logic [NUM_PLAYERS*ITEM_TYPES*CW-1:0] o_item_count,
    output logic [NUM_PLAYERS*2*MAX_SHELLS-1:0]  o_know_map,
    output logic                                 o_phase_item,
    output logic                                 o_phase_shoot,
    output logic                                 o_snap_valid,
    input  logic                                 i_snap_ready,
    output logic [2*MAX_SHELLS-1:0]              o_snap_map,
    output logic                                 o_snap_phase,
`ifdef AI_ENC_SHELL_STATS_EN
    output logic [SW-1:0]                        o_stat_live,
    output logic [SW-1:0]                        o_stat_blank,
    output logic [SW-1:0]                        o_stat_unknown,
`endif
    output logic                                 o_snap_drop
);

    localparam logic [3:0] AI_ITEM_ST  = ST_ITEM_BASE + 4'(AI_PLAYER);
    localparam logic [3:0] AI_SHOOT_ST = ST_SHOOT_BASE + 4'(AI_PLAYER);
    localparam logic [3:0] ITEM_END    = ST_ITEM_BASE + 4'(NUM_PLAYERS);
    localparam logic [3:0] SHOOT_END   = ST_SHOOT_BASE + 4'(NUM_PLAYERS);

    logic [NUM_PLAYERS*2*MAX_SHELLS-1:0] know_q, know_d;
    logic [3:0]                          state_prev;
    logic                                load_q, load_phase_q;
    logic                                ai_turn, turn_entry;
    logic [SW:0]                         target;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_hist
        item_histogram #(
            .ITEM_SLOTS (ITEM_SLOTS),
            .ITEM_TYPES (ITEM_TYPES),
            .CW         (CW)
        ) u_hist (
            .items  (i_items[p*ITEM_SLOTS*4 +: ITEM_SLOTS*4]),
            .counts (o_item_count[p*ITEM_TYPES*CW +: ITEM_TYPES*CW])
        );
    end

    assign o_phase_item  = (i_state >= ST_ITEM_BASE) && (i_state < ITEM_END);
    assign o_phase_shoot = (i_state >= ST_SHOOT_BASE) && (i_state < SHOOT_END);
    assign ai_turn       = (i_state == AI_ITEM_ST) || (i_state == AI_SHOOT_ST);
    assign turn_entry    = ai_turn && (i_state != state_prev);
    // Extra bit so ptr+idx past the chamber never aliases onto a real entry.
    assign target        = {1'b0, i_shell_ptr} + {1'b0, i_report_idx};

    always_comb begin
        logic [1:0] cur, nxt;
        know_d = know_q;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            for (int i = 0; i < MAX_SHELLS; i++) begin
                cur = know_q[(p*MAX_SHELLS+i)*2 +: 2];
                nxt = cur;
                if ((SW+1)'(i) >= {1'b0, i_total_shells}) begin
                    nxt = K_PAD;
                end else if (i_state == ST_LOAD) begin
                    nxt = K_UNKNOWN;
                end else if ((SW+1)'(i) < {1'b0, i_shell_ptr}) begin
                    nxt = {1'b1, ~i_shell_map[i]};
                end else if (i_report_valid && ({1'b0, i_report_player} == (PW+1)'(p))
                             && (target == (SW+1)'(i)) && (cur == K_UNKNOWN)) begin
                    nxt = {1'b1, ~i_report_live};
                end
                know_d[(p*MAX_SHELLS+i)*2 +: 2] = nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            know_q       <= '0;
            state_prev   <= '0;
            load_q       <= 1'b0;
            load_phase_q <= 1'b0;
        end else begin
            know_q       <= know_d;
            state_prev   <= i_state;
            load_q       <= turn_entry;
            load_phase_q <= (i_state == AI_SHOOT_ST);
        end
    end

    assign o_know_map = know_q;

    // valid/ready: snapshot is offered while o_snap_valid is high, map/phase
    // are frozen until the edge sampling valid && ready; leaving the AI turn
    // or a fresh turn entry discards an unaccepted snapshot with a drop pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_snap_valid <= 1'b0;
            o_snap_map   <= '0;
            o_snap_phase <= 1'b0;
            o_snap_drop  <= 1'b0;
        end else begin
            o_snap_drop <= 1'b0;
            if (load_q) begin
                o_snap_map   <= know_q[AI_PLAYER*2*MAX_SHELLS +: 2*MAX_SHELLS];
                o_snap_phase <= load_phase_q;
                o_snap_valid <= 1'b1;
                o_snap_drop  <= o_snap_valid && !i_snap_ready;
            end else if (o_snap_valid && i_snap_ready) begin
                o_snap_valid <= 1'b0;
            end else if (o_snap_valid && !ai_turn) begin
                o_snap_valid <= 1'b0;
                o_snap_drop  <= 1'b1;
            end
        end
    end

`ifdef AI_ENC_SHELL_STATS_EN
    logic [SW-1:0] cnt_live, cnt_blank, cnt_unknown;

    always_comb begin
        logic [1:0] code;
        cnt_live    = '0;
        cnt_blank   = '0;
        cnt_unknown = '0;
        for (int i = 0; i < MAX_SHELLS; i++) begin
            code = know_q[(AI_PLAYER*MAX_SHELLS+i)*2 +: 2];
            if (code == K_LIVE)    cnt_live    = cnt_live + SW'(1);
            if (code == K_BLANK)   cnt_blank   = cnt_blank + SW'(1);
            if (code == K_UNKNOWN) cnt_unknown = cnt_unknown + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_stat_live    <= '0;
            o_stat_blank   <= '0;
            o_stat_unknown <= '0;
        end else if (load_q) begin
            o_stat_live    <= cnt_live;
            o_stat_blank   <= cnt_blank;
            o_stat_unknown <= cnt_unknown;
        end
    end
`endif

endmodule

// File: doc/ai_state_encoder.md
# ai_state_encoder

Parametrised encoder that turns the game controller's raw state into a per-player knowledge view for the AI opponent. It tracks, for each player, which shells in the chamber that player knows to be live or blank. It also counts each player's held items by type. On entry to the AI player's turn it latches a snapshot and offers it on a valid/ready handshake. It sits between the game FSM and the AI decision engine and replaces the fixed two-player, eight-shell encoder.

## Interface
Parameters:
- NUM_PLAYERS, 2: number of players; legal range 2..3.
- MAX_SHELLS, 8: chamber depth.
- ITEM_SLOTS, 6: inventory slots per player.
- ITEM_TYPES, 7: distinct item codes 1..ITEM_TYPES; code 0 means an empty slot.
- AI_PLAYER, 0: index of the player driven by the AI.
- Derived widths: SW = $clog2(MAX_SHELLS+1); PW = $clog2(NUM_PLAYERS); CW = $clog2(ITEM_SLOTS+1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- i_state  in  4  game FSM state.
- i_total_shells  in  SW  shells loaded this round.
- i_shell_ptr  in  SW  number of shells already fired.
- i_shell_map  in  MAX_SHELLS  bit i = 1 when shell i is live.
- i_report_valid  in  1  private reveal strobe.
- i_report_player  in  PW  player receiving the reveal.
- i_report_idx  in  SW  revealed shell, relative to i_shell_ptr.
- i_report_live  in  1  revealed shell is live.
- i_items  in  NUM_PLAYERS*ITEM_SLOTS*4  inventory, 4-bit code per slot, player-major.
- o_item_count  out  NUM_PLAYERS*ITEM_TYPES*CW  per-player count of each type.
- o_know_map  out  NUM_PLAYERS*2*MAX_SHELLS  per-player knowledge codes.
- o_phase_item, o_phase_shoot  out  1  current phase flags.
- o_snap_valid  out  1  snapshot offered.
- i_snap_ready  in  1  AI accepts the snapshot.
- o_snap_map  out  2*MAX_SHELLS  AI player's knowledge at snapshot time.
- o_snap_phase  out  1  0 = item phase, 1 = shoot phase.
- o_snap_drop  out  1  one-cycle pulse when an unaccepted snapshot is discarded.

## Operation
State decoding:
- ST_LOAD = 1.
- Item phase for player p = ST_ITEM_BASE(2) + p.
- Shoot phase for player p = ST_SHOOT_BASE(5) + p.
- o_phase_item / o_phase_shoot are combinational: set for any player's item or shoot state respectively.

Knowledge codes: 00 = pad, 01 = unknown, 10 = known live, 11 = known blank.

Per player p, per entry i, next value is decided in priority order:
1. i >= i_total_shells → 00.
2. i_state == ST_LOAD → 01.
3. i < i_shell_ptr → {1, ~i_shell_map[i]}; fired shells are known to everyone.
4. i_report_valid, i_report_player == p, i == i_shell_ptr + i_report_idx, and current code is 01 → {1, ~i_report_live}.
5. Otherwise hold.

Reveal rules:
- A reveal whose target index is >= i_total_shells is ignored.
- A reveal whose i_report_player >= NUM_PLAYERS is ignored.
- A reveal never overwrites a code that is already known.

Item counts:
- Combinational.
- Count for type t = number of that player's slots holding code t+1.
- Codes 0 and codes > ITEM_TYPES are not counted.

Snapshot handshake:
- Turn entry is detected at cycle N when i_state is the AI_PLAYER item or shoot state and differs from the previous cycle's state.
- At the edge ending cycle N+1, o_snap_map and o_snap_phase are loaded from the AI player's knowledge register and o_snap_valid is set. The snapshot therefore includes any update driven at cycle N.
- o_snap_map and o_snap_phase hold stable while o_snap_valid is high.
- o_snap_valid clears on the edge where it is sampled high together with i_snap_ready.
- If i_state leaves the AI turn states while the snapshot is valid and not accepted: o_snap_valid clears next cycle and o_snap_drop pulses.
- If a new turn entry occurs while a snapshot is pending: the pending one is replaced (drop pulse) and the new one is offered.
- If accept and exit happen in the same cycle, accept wins and there is no drop pulse.

## Timing
- Reset: every knowledge code is 00; state_prev = 0; o_snap_valid = 0; o_snap_map = 0; o_snap_phase = 0; o_snap_drop = 0. Combinational outputs follow their inputs.
- Knowledge maps: 1-cycle latency from the inputs.
- Snapshot: o_snap_valid rises 2 cycles after the turn-entry cycle.
- Minimum handshake: 1 cycle (i_snap_ready already high when valid rises).
- Reset asserted mid-handshake clears everything immediately; no drop pulse is generated.

## Configuration
- AI_ENC_SHELL_STATS_EN defined: adds three registered outputs, o_stat_live, o_stat_blank and o_stat_unknown, each SW wide. They are loaded together with o_snap_map and hold the counts of 10, 11 and 01 codes in the snapshot.
- Undefined: these ports are absent and no counter logic is built.

## Structure
- Shared package ai_enc_pkg holds:
  - the knowledge code enum (K_PAD, K_UNKNOWN, K_LIVE, K_BLANK);
  - ST_LOAD, ST_ITEM_BASE, ST_SHOOT_BASE;
  - an item code typedef.
- Sub-module item_histogram: one instance per player, generated; combinationally maps ITEM_SLOTS codes to ITEM_TYPES counts.

## Test plan
- Reset, then i_state=1 with i_total_shells=5 → at every player, entries 0..4 = 01 and entries 5..7 = 00, one cycle later.
- After load, i_shell_ptr=2 with map bits 0 = 1 and 1 = 0 → every player sees entry 0 = 10 and entry 1 = 11; reveal (player 1, idx 1, live) → only player 1 sees entry 3 = 10; a repeated reveal at the same entry with live=0 leaves 10.
- Items for player 0 = {3,3,0,7,9,3} → count for code 3 = 3, code 7 = 1, all other counts 0; code 9 is ignored.
- i_state 0 → 2 with AI_PLAYER=0 and i_snap_ready=0 for 4 cycles → o_snap_valid rises 2 cycles after the transition, o_snap_map stays stable, and valid clears the cycle after ready=1 is sampled.
- Snapshot pending, then i_state 2 → 4 → o_snap_drop pulses once and o_snap_valid clears; repeat with ready=1 in the exit cycle → no drop pulse.
- rst_n pulsed low while o_snap_valid=1 → all registered outputs read 0 immediately, with no drop pulse.
